// File: rtl/uc_pila_pkg.sv
// Shared definitions for the uc_pila control unit: opcode map, ALU operation codes
// and the RUN/HALT state encoding.
package uc_pkg;

   localparam logic [5:0] OP_J    = 6'b001000;
   localparam logic [5:0] OP_JZ   = 6'b001001;
   localparam logic [5:0] OP_JNZ  = 6'b001010;
   localparam logic [5:0] OP_CALL = 6'b001011;
   localparam logic [5:0] OP_RET  = 6'b001100;
   localparam logic [5:0] OP_HALT = 6'b001111;

   // LI is 0000xx, ALU is 1xxxxx with the operation in opcode[4:2]
   localparam logic [3:0] OP_LI_PFX  = 4'b0000;
   localparam logic       OP_ALU_PFX = 1'b1;

   typedef enum logic [2:0] {
      ALU_A     = 3'b000,
      ALU_NOT_A = 3'b001,
      ALU_ADD   = 3'b010,
      ALU_SUB   = 3'b011,
      ALU_AND   = 3'b100,
      ALU_OR    = 3'b101,
      ALU_NEG_A = 3'b110,
      ALU_NEG_B = 3'b111
   } alu_op_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_e;

   function automatic logic is_li(input logic [5:0] op);
      return op[5:2] == OP_LI_PFX;
   endfunction

   function automatic logic is_alu(input logic [5:0] op);
      return op[5] == OP_ALU_PFX;
   endfunction

endpackage

// File: rtl/uc_pila_if.sv
// Bundle between the control unit and the datapath / program memory.
// master = datapath side, slave = control unit.
interface uc_pila_if #(
   parameter int PC_WIDTH = 10,
   parameter int DEPTH    = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [5:0]          opcode;
   logic                z;
   logic [PC_WIDTH-1:0] pc_plus1;

   logic                s_inc;
   logic                s_inm;
   logic                we3;
   logic                wez;
   logic [2:0]          op_alu;
   logic                s_ret;
   logic                pc_en;
   logic [PC_WIDTH-1:0] ret_addr;
   logic [CW-1:0]       count;
   logic                halted;
   logic [1:0]          fault;

   modport master (
      output opcode, z, pc_plus1,
      input  s_inc, s_inm, we3, wez, op_alu, s_ret, pc_en,
      input  ret_addr, count, halted, fault
   );

   modport slave (
      input  opcode, z, pc_plus1,
      output s_inc, s_inm, we3, wez, op_alu, s_ret, pc_en,
      output ret_addr, count, halted, fault
   );

endinterface

// File: rtl/uc_pila_ret.sv
// Return-address LIFO. Storage is not reset; only the occupancy counter is.
// Top reads as zero while empty.
module pila_ret #(
   parameter int W     = 10,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic [W-1:0]  i_data,
   output logic          o_full,
   output logic          o_empty,
   output logic [W-1:0]  o_top,
   output logic [CW-1:0] o_count
);

   logic [W-1:0]  r_mem [DEPTH];
   logic [CW-1:0] r_count;
   logic [AW-1:0] w_wr_idx;
   logic [AW-1:0] w_top_idx;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty & ~i_push;

   // count wraps to 0 in the low bits when full, so top index lands on DEPTH-1
   assign w_wr_idx  = r_count[AW-1:0];
   assign w_top_idx = w_wr_idx - AW'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (w_do_push) begin
         r_count <= r_count + CW'(1);
      end else if (w_do_pop) begin
         r_count <= r_count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[w_wr_idx] <= i_data;
      end
   end

   assign o_top   = o_empty ? '0 : r_mem[w_top_idx];
   assign o_count = r_count;

endmodule

// File: rtl/uc_pila.sv
// Single-cycle CPU control unit: opcode decode, CALL/RET via return stack, RUN/HALT FSM
// with sticky stack faults.
//   state   | meaning
//   ST_RUN  | decoding instructions, PC advances every cycle
//   ST_HALT | everything frozen until reset (HALT opcode or stack fault)
module uc_pila
   import uc_pkg::*;
#(
   parameter int PC_WIDTH = 10,
   parameter int DEPTH    = 8
) (
   input logic        clk,
   input logic        reset,
   uc_pila_if.slave   bus
);

   localparam int CW = $clog2(DEPTH) + 1;

   state_e              r_state;
   state_e              w_state_nxt;
   logic [1:0]          r_fault;
   logic [1:0]          w_fault_set;

   logic                w_s_inc;
   logic                w_s_inm;
   logic                w_we3;
   logic                w_wez;
   alu_op_e             w_op_alu;
   logic                w_s_ret;
   logic                w_pc_en;
   logic                w_push;
   logic                w_pop;
   logic                w_full;
   logic                w_empty;
   logic [PC_WIDTH-1:0] w_top;
   logic [CW-1:0]       w_count;

   pila_ret #(
      .W     (PC_WIDTH),
      .DEPTH (DEPTH)
   ) u_pila_ret (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (bus.pc_plus1),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_top   (w_top),
      .o_count (w_count)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_RUN;
         r_fault <= 2'b00;
      end else begin
         r_state <= w_state_nxt;
         r_fault <= r_fault | w_fault_set;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_fault_set = 2'b00;
      w_s_inc     = 1'b1;
      w_s_inm     = 1'b0;
      w_we3       = 1'b0;
      w_wez       = 1'b0;
      w_op_alu    = ALU_A;
      w_s_ret     = 1'b0;
      w_pc_en     = 1'b0;
      w_push      = 1'b0;
      w_pop       = 1'b0;

      case (r_state)
         ST_RUN: begin
            w_pc_en = 1'b1;
            if (is_alu(bus.opcode)) begin
               w_we3    = 1'b1;
               w_wez    = 1'b1;
               w_op_alu = alu_op_e'(bus.opcode[4:2]);
            end else if (is_li(bus.opcode)) begin
               w_s_inm = 1'b1;
               w_we3   = 1'b1;
            end else begin
               case (bus.opcode)
                  OP_J:   w_s_inc = 1'b0;
                  OP_JZ:  w_s_inc = ~bus.z;
                  OP_JNZ: w_s_inc = bus.z;
                  OP_CALL: begin
                     w_s_inc = 1'b0;
                     if (w_full) begin
                        w_pc_en        = 1'b0;
                        w_fault_set[1] = 1'b1;
                        w_state_nxt    = ST_HALT;
                     end else begin
                        w_push = 1'b1;
                     end
                  end
                  OP_RET: begin
                     w_s_inc = 1'b0;
                     if (w_empty) begin
                        w_pc_en        = 1'b0;
                        w_fault_set[0] = 1'b1;
                        w_state_nxt    = ST_HALT;
                     end else begin
                        w_s_ret = 1'b1;
                        w_pop   = 1'b1;
                     end
                  end
                  OP_HALT: w_state_nxt = ST_HALT;
                  default: ;
               endcase
            end
         end
         ST_HALT: ;
         default: w_state_nxt = ST_RUN;
      endcase
   end

   assign bus.s_inc    = w_s_inc;
   assign bus.s_inm    = w_s_inm;
   assign bus.we3      = w_we3;
   assign bus.wez      = w_wez;
   assign bus.op_alu   = w_op_alu;
   assign bus.s_ret    = w_s_ret;
   assign bus.pc_en    = w_pc_en;
   assign bus.ret_addr = w_top;
   assign bus.count    = w_count;
   assign bus.halted   = (r_state == ST_HALT);
   assign bus.fault    = r_fault;

endmodule

// File: tb/tb_uc_pila.sv
// Directed bench for uc_pila: decode, CALL/RET stack, overflow/underflow faults, HALT, async reset.
module tb_uc_pila;

   localparam int PC_WIDTH = 10;
   localparam int DEPTH    = 8;

   localparam logic [5:0] OPC_NOP  = 6'b001101;
   localparam logic [5:0] OPC_J    = 6'b001000;
   localparam logic [5:0] OPC_JZ   = 6'b001001;
   localparam logic [5:0] OPC_JNZ  = 6'b001010;
   localparam logic [5:0] OPC_CALL = 6'b001011;
   localparam logic [5:0] OPC_RET  = 6'b001100;
   localparam logic [5:0] OPC_HALT = 6'b001111;
   localparam logic [5:0] OPC_LI   = 6'b000010;
   localparam logic [5:0] OPC_ADD  = 6'b101000;
   localparam logic [5:0] OPC_AND  = 6'b110000;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   uc_pila_if #(.PC_WIDTH(PC_WIDTH), .DEPTH(DEPTH)) bus ();

   uc_pila #(.PC_WIDTH(PC_WIDTH), .DEPTH(DEPTH)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic apply(input logic [5:0] op, input logic zz, input logic [PC_WIDTH-1:0] pc);
      bus.opcode   = op;
      bus.z        = zz;
      bus.pc_plus1 = pc;
      #2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset        = 1'b1;
      bus.opcode   = OPC_NOP;
      bus.z        = 1'b0;
      bus.pc_plus1 = '0;
      #1;
      check_val("rst_count", 32'(bus.count), 32'd0);
      check_val("rst_halted", 32'(bus.halted), 32'd0);
      check_val("rst_fault", 32'(bus.fault), 32'd0);
      check_val("rst_ret_addr", 32'(bus.ret_addr), 32'd0);
      #11;
      reset = 1'b0;
      tick();

      // plain decode
      apply(OPC_ADD, 1'b0, 10'h000);
      check_val("alu_s_inc", 32'(bus.s_inc), 32'd1);
      check_val("alu_we3", 32'(bus.we3), 32'd1);
      check_val("alu_wez", 32'(bus.wez), 32'd1);
      check_val("alu_op", 32'(bus.op_alu), 32'd2);
      check_val("alu_pc_en", 32'(bus.pc_en), 32'd1);
      check_val("alu_count", 32'(bus.count), 32'd0);
      check_val("alu_s_inm", 32'(bus.s_inm), 32'd0);
      apply(OPC_AND, 1'b0, 10'h000);
      check_val("and_op", 32'(bus.op_alu), 32'd4);
      apply(OPC_JZ, 1'b1, 10'h000);
      check_val("jz_z1_s_inc", 32'(bus.s_inc), 32'd0);
      check_val("jz_we3", 32'(bus.we3), 32'd0);
      check_val("jz_wez", 32'(bus.wez), 32'd0);
      apply(OPC_JZ, 1'b0, 10'h000);
      check_val("jz_z0_s_inc", 32'(bus.s_inc), 32'd1);
      apply(OPC_JNZ, 1'b1, 10'h000);
      check_val("jnz_z1_s_inc", 32'(bus.s_inc), 32'd1);
      check_val("jnz_we3", 32'(bus.we3), 32'd0);
      check_val("jnz_wez", 32'(bus.wez), 32'd0);
      apply(OPC_J, 1'b0, 10'h000);
      check_val("j_s_inc", 32'(bus.s_inc), 32'd0);
      apply(OPC_LI, 1'b0, 10'h000);
      check_val("li_s_inm", 32'(bus.s_inm), 32'd1);
      check_val("li_we3", 32'(bus.we3), 32'd1);
      check_val("li_wez", 32'(bus.wez), 32'd0);
      apply(OPC_NOP, 1'b0, 10'h000);
      check_val("nop_s_inc", 32'(bus.s_inc), 32'd1);
      check_val("nop_we3", 32'(bus.we3), 32'd0);
      tick();

      // single CALL then RET
      apply(OPC_CALL, 1'b0, 10'h005);
      check_val("call_s_inc", 32'(bus.s_inc), 32'd0);
      check_val("call_pc_en", 32'(bus.pc_en), 32'd1);
      tick();
      check_val("call_count", 32'(bus.count), 32'd1);
      check_val("call_ret_addr", 32'(bus.ret_addr), 32'h005);
      apply(OPC_RET, 1'b0, 10'h3ff);
      check_val("ret_s_ret", 32'(bus.s_ret), 32'd1);
      check_val("ret_pc_en", 32'(bus.pc_en), 32'd1);
      check_val("ret_addr_in_ret", 32'(bus.ret_addr), 32'h005);
      tick();
      check_val("ret_count", 32'(bus.count), 32'd0);
      check_val("ret_empty_addr", 32'(bus.ret_addr), 32'd0);

      // nested calls
      apply(OPC_CALL, 1'b0, 10'h011);
      tick();
      apply(OPC_CALL, 1'b0, 10'h022);
      tick();
      apply(OPC_CALL, 1'b0, 10'h033);
      tick();
      check_val("nest_count3", 32'(bus.count), 32'd3);
      apply(OPC_RET, 1'b0, 10'h000);
      check_val("nest_ret1", 32'(bus.ret_addr), 32'h033);
      check_val("nest_s_ret1", 32'(bus.s_ret), 32'd1);
      tick();
      apply(OPC_RET, 1'b0, 10'h000);
      check_val("nest_ret2", 32'(bus.ret_addr), 32'h022);
      tick();
      apply(OPC_RET, 1'b0, 10'h000);
      check_val("nest_ret3", 32'(bus.ret_addr), 32'h011);
      tick();
      check_val("nest_count0", 32'(bus.count), 32'd0);
      apply(OPC_NOP, 1'b0, 10'h000);
      tick();

      // overflow
      for (int i = 0; i < DEPTH; i++) begin
         apply(OPC_CALL, 1'b0, PC_WIDTH'(10'h100 + i));
         tick();
      end
      check_val("ovf_full_count", 32'(bus.count), 32'd8);
      apply(OPC_CALL, 1'b0, 10'h1ff);
      check_val("ovf_pc_en", 32'(bus.pc_en), 32'd0);
      check_val("ovf_we3", 32'(bus.we3), 32'd0);
      check_val("ovf_halted_pre", 32'(bus.halted), 32'd0);
      tick();
      check_val("ovf_halted", 32'(bus.halted), 32'd1);
      check_val("ovf_fault", 32'(bus.fault), 32'd2);
      check_val("ovf_count", 32'(bus.count), 32'd8);
      check_val("ovf_ret_addr", 32'(bus.ret_addr), 32'h107);
      apply(OPC_ADD, 1'b0, 10'h000);
      check_val("halt_alu_we3", 32'(bus.we3), 32'd0);
      check_val("halt_alu_wez", 32'(bus.wez), 32'd0);
      check_val("halt_alu_op", 32'(bus.op_alu), 32'd0);
      check_val("halt_alu_s_inc", 32'(bus.s_inc), 32'd1);
      check_val("halt_pc_en", 32'(bus.pc_en), 32'd0);
      apply(OPC_RET, 1'b0, 10'h000);
      check_val("halt_ret_s_ret", 32'(bus.s_ret), 32'd0);
      tick();
      check_val("halt_frozen_count", 32'(bus.count), 32'd8);

      // async reset without an edge
      reset = 1'b1;
      #1;
      check_val("arst_halted", 32'(bus.halted), 32'd0);
      check_val("arst_fault", 32'(bus.fault), 32'd0);
      check_val("arst_count", 32'(bus.count), 32'd0);
      check_val("arst_ret_addr", 32'(bus.ret_addr), 32'd0);
      apply(OPC_NOP, 1'b0, 10'h000);
      reset = 1'b0;
      tick();

      // underflow
      apply(OPC_RET, 1'b0, 10'h000);
      check_val("udf_s_ret", 32'(bus.s_ret), 32'd0);
      check_val("udf_pc_en", 32'(bus.pc_en), 32'd0);
      tick();
      check_val("udf_fault", 32'(bus.fault), 32'd1);
      check_val("udf_halted", 32'(bus.halted), 32'd1);
      check_val("udf_count", 32'(bus.count), 32'd0);

      reset = 1'b1;
      #1;
      check_val("arst2_fault", 32'(bus.fault), 32'd0);
      check_val("arst2_halted", 32'(bus.halted), 32'd0);
      apply(OPC_NOP, 1'b0, 10'h000);
      reset = 1'b0;
      tick();

      // HALT opcode
      apply(OPC_HALT, 1'b0, 10'h000);
      check_val("hlt_s_inc", 32'(bus.s_inc), 32'd1);
      check_val("hlt_pc_en", 32'(bus.pc_en), 32'd1);
      check_val("hlt_halted_pre", 32'(bus.halted), 32'd0);
      tick();
      check_val("hlt_halted", 32'(bus.halted), 32'd1);
      check_val("hlt_fault", 32'(bus.fault), 32'd0);
      apply(OPC_LI, 1'b0, 10'h000);
      check_val("hlt_li_we3", 32'(bus.we3), 32'd0);
      check_val("hlt_li_s_inm", 32'(bus.s_inm), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
